// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared types and defaults for the performance counter bank
package perf_pkg;
   typedef enum logic {WRAP = 1'b0, SAT = 1'b1} ovf_mode_e;

   localparam int SNAP_CNT_W = 8;
   localparam int DEF_NUM_CH = 4;
   localparam int DEF_CNT_W  = 19;

   function automatic ovf_mode_e mode_from_param(input int saturate);
      return (saturate != 0) ? SAT : WRAP;
   endfunction
endpackage

// File: rtl/perf_counter_ch.sv
// rtl/perf_counter_ch.sv - one live event counter with sticky overflow and shadow copy
module perf_counter_ch
   import perf_pkg::*;
#(
   parameter int        CNT_W = DEF_CNT_W,
   parameter ovf_mode_e MODE  = WRAP
) (
   input  logic             clkFPGA,
   input  logic             rst,
   input  logic             clear,
   input  logic             snap,
   input  logic             inc,
   output logic [CNT_W-1:0] shadow,
   output logic             ovf
);
   localparam logic [CNT_W-1:0] MAX_VAL = '1;

   logic [CNT_W-1:0] live_q, live_d;
   logic [CNT_W-1:0] shadow_q, shadow_d;
   logic             ovf_q, ovf_d;

   // Shadow samples the pre-update live value, so a same-cycle clear or increment is not seen.
   always_comb begin
      live_d   = live_q;
      shadow_d = shadow_q;
      ovf_d    = ovf_q;
      if (snap) begin
         shadow_d = live_q;
      end
      if (clear) begin
         live_d = '0;
         ovf_d  = 1'b0;
      end else if (inc) begin
         if (live_q != MAX_VAL) begin
            live_d = live_q + CNT_W'(1);
         end else begin
            ovf_d  = 1'b1;
            live_d = (MODE == SAT) ? MAX_VAL : '0;
         end
      end
   end

   always_ff @(posedge clkFPGA) begin
      if (rst) begin
         live_q   <= '0;
         shadow_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         live_q   <= live_d;
         shadow_q <= shadow_d;
         ovf_q    <= ovf_d;
      end
   end

   assign shadow = shadow_q;
   assign ovf    = ovf_q;
endmodule

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - bank of event counters with atomic snapshot and registered read port
module perf_counter_bank
   import perf_pkg::*;
#(
   parameter int  NUM_CH   = DEF_NUM_CH,
   parameter int  CNT_W    = DEF_CNT_W,
   parameter int  SATURATE = 0,
   localparam int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                  clkFPGA,
   input  logic                  rst,
   input  logic [NUM_CH-1:0]     event_i,
   input  logic                  enable,
   input  logic                  clear,
   input  logic                  snap,
   input  logic                  rd_en,
   input  logic [SEL_W-1:0]      rd_sel,
   output logic [CNT_W-1:0]      rd_data,
   output logic                  rd_valid,
   output logic                  rd_err,
   output logic [NUM_CH-1:0]     ovf,
   output logic [SNAP_CNT_W-1:0] snap_cnt
);
   localparam ovf_mode_e MODE = mode_from_param(SATURATE);

   logic [CNT_W-1:0] shadow [NUM_CH];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      perf_counter_ch #(
         .CNT_W (CNT_W),
         .MODE  (MODE)
      ) u_ch (
         .clkFPGA (clkFPGA),
         .rst     (rst),
         .clear   (clear),
         .snap    (snap),
         .inc     (enable && event_i[i]),
         .shadow  (shadow[i]),
         .ovf     (ovf[i])
      );
   end

   logic [CNT_W-1:0]      sel_val;
   logic                  sel_hit;
   logic [CNT_W-1:0]      rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  rd_err_q, rd_err_d;
   logic [SNAP_CNT_W-1:0] snap_cnt_q, snap_cnt_d;

   // An index with no matching channel leaves sel_val at zero and flags the error.
   always_comb begin
      sel_val = '0;
      sel_hit = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (rd_sel == SEL_W'(i)) begin
            sel_val = shadow[i];
            sel_hit = 1'b1;
         end
      end
      rd_valid_d = rd_en;
      rd_data_d  = rd_data_q;
      rd_err_d   = rd_err_q;
      if (rd_en) begin
         rd_data_d = sel_val;
         rd_err_d  = !sel_hit;
      end
      snap_cnt_d = snap ? snap_cnt_q + SNAP_CNT_W'(1) : snap_cnt_q;
   end

   always_ff @(posedge clkFPGA) begin
      if (rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
         snap_cnt_q <= '0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         rd_err_q   <= rd_err_d;
         snap_cnt_q <= snap_cnt_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign rd_err   = rd_err_q;
   assign snap_cnt = snap_cnt_q;
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - three bank configurations driven in lockstep and checked against a reference model
module tb_perf_counter_bank;
   localparam int NDUT = 3;
   localparam int MAXV = 15;

   logic       clk = 1'b0;
   logic       rst = 1'b0, enable = 1'b0, clear = 1'b0, snap = 1'b0, rd_en = 1'b0;
   logic [3:0] ev = '0;
   logic [1:0] rd_sel = '0;

   logic [3:0] o_data  [NDUT];
   logic       o_valid [NDUT];
   logic       o_err   [NDUT];
   logic [3:0] o_ovf   [NDUT];
   logic [7:0] o_snap  [NDUT];
   logic [2:0] ovf2;

   always #5 clk = ~clk;

   perf_counter_bank #(.NUM_CH(4), .CNT_W(4), .SATURATE(0)) dut0 (
      .clkFPGA(clk), .rst(rst), .event_i(ev), .enable(enable), .clear(clear), .snap(snap),
      .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(o_data[0]), .rd_valid(o_valid[0]),
      .rd_err(o_err[0]), .ovf(o_ovf[0]), .snap_cnt(o_snap[0]));
   perf_counter_bank #(.NUM_CH(4), .CNT_W(4), .SATURATE(1)) dut1 (
      .clkFPGA(clk), .rst(rst), .event_i(ev), .enable(enable), .clear(clear), .snap(snap),
      .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(o_data[1]), .rd_valid(o_valid[1]),
      .rd_err(o_err[1]), .ovf(o_ovf[1]), .snap_cnt(o_snap[1]));
   perf_counter_bank #(.NUM_CH(3), .CNT_W(4), .SATURATE(0)) dut2 (
      .clkFPGA(clk), .rst(rst), .event_i(ev[2:0]), .enable(enable), .clear(clear), .snap(snap),
      .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(o_data[2]), .rd_valid(o_valid[2]),
      .rd_err(o_err[2]), .ovf(ovf2), .snap_cnt(o_snap[2]));
   assign o_ovf[2] = {1'b0, ovf2};

   // Reference model: plain integer counters per configuration
   int  nch [NDUT] = '{4, 4, 3};
   bit  sat [NDUT] = '{0, 1, 0};
   int  m_live [NDUT][4];
   int  m_shadow [NDUT][4];
   bit  m_ovf [NDUT][4];
   int  m_data [NDUT];
   bit  m_valid [NDUT];
   bit  m_err [NDUT];
   int  m_snap [NDUT];

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit en, input logic [3:0] e, input bit cl,
                             input bit sn, input bit re, input int sel);
      for (int d = 0; d < NDUT; d++) begin
         if (r) begin
            for (int i = 0; i < 4; i++) begin
               m_live[d][i] = 0; m_shadow[d][i] = 0; m_ovf[d][i] = 0;
            end
            m_data[d] = 0; m_valid[d] = 0; m_err[d] = 0; m_snap[d] = 0;
         end else begin
            m_valid[d] = re;
            if (re) begin
               m_err[d]  = (sel >= nch[d]);
               m_data[d] = m_err[d] ? 0 : m_shadow[d][sel];
            end
            for (int i = 0; i < nch[d]; i++) begin
               if (sn) m_shadow[d][i] = m_live[d][i];
               if (cl) begin
                  m_live[d][i] = 0;
                  m_ovf[d][i]  = 0;
               end else if (en && e[i]) begin
                  if (m_live[d][i] == MAXV) m_ovf[d][i] = 1;
                  m_live[d][i] = sat[d] ? ((m_live[d][i] + 1 > MAXV) ? MAXV : m_live[d][i] + 1)
                                        : (m_live[d][i] + 1) % (MAXV + 1);
               end
            end
            if (sn) m_snap[d] = (m_snap[d] + 1) % 256;
         end
      end
   endtask

   task automatic compare_all();
      logic [3:0] exp_ovf;
      for (int d = 0; d < NDUT; d++) begin
         exp_ovf = '0;
         for (int i = 0; i < nch[d]; i++) exp_ovf[i] = m_ovf[d][i];
         chk($sformatf("dut%0d rd_valid", d), o_valid[d], m_valid[d]);
         chk($sformatf("dut%0d rd_data", d), o_data[d], m_data[d]);
         chk($sformatf("dut%0d rd_err", d), o_err[d], m_err[d]);
         chk($sformatf("dut%0d ovf", d), o_ovf[d], exp_ovf);
         chk($sformatf("dut%0d snap_cnt", d), o_snap[d], m_snap[d]);
      end
   endtask

   task automatic cyc(input bit r, input bit en, input logic [3:0] e, input bit cl,
                      input bit sn, input bit re, input int sel);
      rst = r; enable = en; ev = e; clear = cl; snap = sn; rd_en = re; rd_sel = sel[1:0];
      @(posedge clk);
      model_step(r, en, e, cl, sn, re, sel);
      #1;
      compare_all();
   endtask

   typedef struct {
      bit         r, en;
      logic [3:0] e;
      bit         cl, sn, re;
      int         sel;
      int         x_valid, x_data, x_err, x_ovf, x_snap;
   } vec_t;

   vec_t tbl[20];

   initial begin
      // Reset, count 0101 for five cycles, snapshot, read back, then gated events
      tbl[0]  = '{1, 0, 4'b0000, 0, 0, 0, 0,  0, 0, 0, 0, 0};
      for (int k = 1; k <= 5; k++)
         tbl[k] = '{0, 1, 4'b0101, 0, 0, 0, 0,  0, 0, 0, 0, 0};
      tbl[6]  = '{0, 0, 4'b0000, 0, 1, 0, 0,  0, 0, 0, 0, 1};
      tbl[7]  = '{0, 0, 4'b0000, 0, 0, 1, 0,  1, 5, 0, 0, 1};
      tbl[8]  = '{0, 0, 4'b0000, 0, 0, 1, 1,  1, 0, 0, 0, 1};
      tbl[9]  = '{0, 0, 4'b0000, 0, 0, 1, 3,  1, 0, 0, 0, 1};
      tbl[10] = '{0, 0, 4'b0000, 0, 0, 1, 2,  1, 5, 0, 0, 1};
      tbl[11] = '{0, 0, 4'b0000, 0, 0, 0, 0,  0, 5, 0, 0, 1};
      for (int k = 12; k <= 15; k++)
         tbl[k] = '{0, 0, 4'b1111, 0, 0, 0, 0,  0, 5, 0, 0, 1};
      tbl[16] = '{0, 0, 4'b0000, 0, 1, 0, 0,  0, 5, 0, 0, 2};
      tbl[17] = '{0, 0, 4'b0000, 0, 0, 1, 0,  1, 5, 0, 0, 2};
      tbl[18] = '{0, 0, 4'b0000, 0, 0, 1, 3,  1, 0, 0, 0, 2};
      tbl[19] = '{0, 0, 4'b0000, 0, 0, 0, 0,  0, 0, 0, 0, 2};

      @(negedge clk);
      for (int k = 0; k < 20; k++) begin
         cyc(tbl[k].r, tbl[k].en, tbl[k].e, tbl[k].cl, tbl[k].sn, tbl[k].re, tbl[k].sel);
         chk($sformatf("tbl%0d rd_valid", k), o_valid[0], tbl[k].x_valid);
         chk($sformatf("tbl%0d rd_data", k), o_data[0], tbl[k].x_data);
         chk($sformatf("tbl%0d rd_err", k), o_err[0], tbl[k].x_err);
         chk($sformatf("tbl%0d ovf", k), o_ovf[0], tbl[k].x_ovf);
         chk($sformatf("tbl%0d snap_cnt", k), o_snap[0], tbl[k].x_snap);
      end

      // Wrap versus saturate
      cyc(0, 0, 4'b0000, 1, 0, 0, 0);
      repeat (17) cyc(0, 1, 4'b0010, 0, 0, 0, 0);
      chk("wrap ovf1", o_ovf[0][1], 1);
      chk("sat ovf1", o_ovf[1][1], 1);
      cyc(0, 0, 4'b0000, 0, 1, 0, 0);
      cyc(0, 0, 4'b0000, 0, 0, 1, 1);
      chk("wrap rd ch1", o_data[0], 1);
      chk("sat rd ch1", o_data[1], 15);
      repeat (20) cyc(0, 1, 4'b0100, 0, 0, 0, 0);
      cyc(0, 0, 4'b0000, 0, 1, 0, 0);
      cyc(0, 0, 4'b0000, 0, 0, 1, 2);
      chk("sat rd ch2 after 20", o_data[1], 15);
      chk("wrap rd ch2 after 20", o_data[0], 4);
      repeat (3) cyc(0, 1, 4'b0100, 0, 0, 0, 0);
      cyc(0, 0, 4'b0000, 0, 1, 0, 0);
      cyc(0, 0, 4'b0000, 0, 0, 1, 2);
      chk("sat rd ch2 after 23", o_data[1], 15);
      chk("wrap rd ch2 after 23", o_data[0], 7);
      cyc(0, 0, 4'b0000, 1, 0, 0, 0);
      chk("clear ovf wrap", o_ovf[0], 0);
      chk("clear ovf sat", o_ovf[1], 0);
      cyc(0, 0, 4'b0000, 0, 1, 0, 0);
      cyc(0, 0, 4'b0000, 0, 0, 1, 1);
      chk("rd ch1 after clear", o_data[0], 0);

      // Event, snap, clear and read all in one cycle
      repeat (7) cyc(0, 1, 4'b0001, 0, 0, 0, 0);
      cyc(0, 1, 4'b0001, 1, 1, 1, 0);
      chk("simul rd old shadow", o_data[0], 0);
      chk("simul rd_valid", o_valid[0], 1);
      cyc(0, 0, 4'b0000, 0, 0, 1, 0);
      chk("simul shadow0", o_data[0], 7);
      cyc(0, 0, 4'b0000, 0, 1, 1, 0);
      chk("snap+rd old", o_data[0], 7);
      cyc(0, 0, 4'b0000, 0, 0, 1, 0);
      chk("live0 cleared", o_data[0], 0);

      // Reset during active counting and an outstanding read
      cyc(0, 1, 4'b1111, 0, 0, 1, 1);
      cyc(1, 1, 4'b1111, 0, 0, 1, 1);
      chk("rst rd_valid", o_valid[0], 0);
      chk("rst rd_data", o_data[0], 0);
      chk("rst snap_cnt", o_snap[0], 0);
      chk("rst ovf", o_ovf[0], 0);

      // Out-of-range index on the three-channel bank, then snap counter wrap
      repeat (2) cyc(0, 1, 4'b1111, 0, 0, 0, 0);
      cyc(0, 0, 4'b0000, 0, 1, 0, 0);
      cyc(0, 0, 4'b0000, 0, 0, 1, 3);
      chk("oor rd_err", o_err[2], 1);
      chk("oor rd_data", o_data[2], 0);
      chk("oor rd_valid", o_valid[2], 1);
      chk("in-range ch3", o_data[0], 2);
      cyc(0, 0, 4'b0000, 0, 0, 1, 0);
      chk("oor err cleared", o_err[2], 0);
      chk("oor next rd", o_data[2], 2);
      cyc(1, 0, 4'b0000, 0, 0, 0, 0);
      repeat (255) cyc(0, 0, 4'b0000, 0, 1, 0, 0);
      chk("snap_cnt 255", o_snap[0], 255);
      cyc(0, 0, 4'b0000, 0, 1, 0, 0);
      chk("snap_cnt wrap", o_snap[0], 0);

      // Random traffic against the model
      repeat (600) begin
         cyc($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, 4'($urandom),
             $urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0, 1'($urandom),
             int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
